// File: rtl/toggle_handshake_rx.sv
// Responder side of a two-phase toggle handshake: captures data_in on each req flip, presents it valid/ready.
// Latency: req flip -> dout_valid after SYNC_STAGES+1 edges; ack_tgl flips on the accepting edge.
// Backpressure: dout holds while dout_ready is low; ack is withheld, which stalls the sender.
module toggle_handshake_rx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_tgl,
  input  logic [DATA_W-1:0] data_in,
  output logic              ack_tgl,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [CNT_W-1:0]  xfer_cnt,
  output logic              err_overrun
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   req_prev_q, req_prev_d;
  logic                   ack_q, ack_d;
  logic [DATA_W-1:0]      dout_q, dout_d;
  logic                   dout_valid_q, dout_valid_d;
  logic [CNT_W-1:0]       xfer_cnt_q, xfer_cnt_d;
  logic                   err_q, err_d;
  logic [0:0]             state_q, state_d;

  logic req_s;
  logic pending;
  logic req_edge;
  logic accept;

  assign req_s    = sync_q[SYNC_STAGES-1];
  // A word is outstanding whenever the synchronised request parity disagrees with our ack.
  assign pending  = req_s ^ ack_q;
  assign req_edge = req_s ^ req_prev_q;
  assign accept   = (state_q == ST_HOLD) && dout_valid_q && dout_ready;

  // Next-state: synchroniser shift, capture in IDLE, release/ack in HOLD, overrun detection.
  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], req_tgl};
    req_prev_d   = req_s;
    ack_d        = ack_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    xfer_cnt_d   = xfer_cnt_q;
    err_d        = err_q;
    state_d      = state_q;
    case (state_q)
      ST_IDLE: begin
        if (pending) begin
          dout_d       = data_in;
          dout_valid_d = 1'b1;
          state_d      = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (accept) begin
          dout_valid_d = 1'b0;
          ack_d        = ~ack_q;
          xfer_cnt_d   = xfer_cnt_q + CNT_W'(1);
          state_d      = ST_IDLE;
        end else if (req_edge) begin
          // Sender flipped again before we acked: the extra flip only folds into
          // parity, so the word it announced is lost. Flag it, keep the held word.
          err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset overrides every event, including a pending acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q       <= '0;
      req_prev_q   <= 1'b0;
      ack_q        <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      xfer_cnt_q   <= '0;
      err_q        <= 1'b0;
      state_q      <= ST_IDLE;
    end else begin
      sync_q       <= sync_d;
      req_prev_q   <= req_prev_d;
      ack_q        <= ack_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      xfer_cnt_q   <= xfer_cnt_d;
      err_q        <= err_d;
      state_q      <= state_d;
    end
  end

  assign ack_tgl     = ack_q;
  assign dout        = dout_q;
  assign dout_valid  = dout_valid_q;
  assign xfer_cnt    = xfer_cnt_q;
  assign err_overrun = err_q;

endmodule

// File: tb/tb_toggle_handshake_rx.sv
// Directed bench for toggle_handshake_rx: two instances share all inputs,
// one with a 16-bit transfer counter and one with a 2-bit counter to show wrap.
// Outputs are sampled 1 time unit after each rising edge.
module tb_toggle_handshake_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_tgl;
  logic [7:0] data_in;
  logic       dout_ready;

  logic        ack_a, valid_a, err_a;
  logic [7:0]  dout_a;
  logic [15:0] cnt_a;
  logic        ack_b, valid_b, err_b;
  logic [7:0]  dout_b;
  logic [1:0]  cnt_b;

  int errors = 0;
  int checks = 0;

  toggle_handshake_rx #(.DATA_W(8), .SYNC_STAGES(2), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .req_tgl(req_tgl), .data_in(data_in),
    .ack_tgl(ack_a), .dout(dout_a), .dout_valid(valid_a), .dout_ready(dout_ready),
    .xfer_cnt(cnt_a), .err_overrun(err_a)
  );

  toggle_handshake_rx #(.DATA_W(8), .SYNC_STAGES(2), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .req_tgl(req_tgl), .data_in(data_in),
    .ack_tgl(ack_b), .dout(dout_b), .dout_valid(valid_b), .dout_ready(dout_ready),
    .xfer_cnt(cnt_b), .err_overrun(err_b)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    req_tgl = 1'b0;
    rst     = 1'b1;
    step();
    step();
    rst     = 1'b0;
  endtask

  // Sender model: flip req with a new word, then wait (bounded) for the ack flip.
  task automatic send_word(input logic [7:0] w, input string tag);
    int seen;
    seen    = 0;
    data_in = w;
    req_tgl = ~req_tgl;
    for (int i = 0; i < 20 && ack_a !== req_tgl; i++) begin
      step();
      if (valid_a === 1'b1) begin
        seen++;
        chk({tag, "_dout"}, dout_a, w);
      end
    end
    chk({tag, "_ack"}, ack_a, req_tgl);
    chk({tag, "_captures"}, seen, 1);
  endtask

  logic [1:0] exp_b [5];

  initial begin
    exp_b = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    // 1: reset with req_tgl high, then release and measure capture latency
    rst = 1'b1; req_tgl = 1'b1; dout_ready = 1'b0; data_in = 8'h3C;
    repeat (3) step();
    chk("rst_ack", ack_a, 0);
    chk("rst_dout", dout_a, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_cnt", cnt_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_cnt_b", cnt_b, 0);
    rst = 1'b0;
    step(); chk("lat_e1_valid", valid_a, 0);
    step(); chk("lat_e2_valid", valid_a, 0);
    step(); chk("lat_e3_valid", valid_a, 1);
    chk("lat_e3_dout", dout_a, 8'h3C);
    dout_ready = 1'b1;
    step();
    chk("lat_acc_valid", valid_a, 0);
    chk("lat_acc_ack", ack_a, 1);
    chk("lat_acc_cnt", cnt_a, 1);

    // 2: single word with ready tied high
    do_reset();
    data_in = 8'hA5; req_tgl = 1'b1;
    step(); step();
    chk("t2_pre_valid", valid_a, 0);
    step();
    chk("t2_valid", valid_a, 1);
    chk("t2_dout", dout_a, 8'hA5);
    chk("t2_ack_before", ack_a, 0);
    step();
    chk("t2_valid_drop", valid_a, 0);
    chk("t2_ack", ack_a, 1);
    chk("t2_cnt", cnt_a, 1);
    chk("t2_dout_kept", dout_a, 8'hA5);
    step();
    chk("t2_no_recapture", valid_a, 0);

    // 3: backpressure for 5 cycles
    do_reset();
    dout_ready = 1'b0;
    data_in = 8'hA5; req_tgl = 1'b1;
    repeat (3) step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("t3_hold%0d_valid", i), valid_a, 1);
      chk($sformatf("t3_hold%0d_dout", i), dout_a, 8'hA5);
      chk($sformatf("t3_hold%0d_ack", i), ack_a, 0);
    end
    dout_ready = 1'b1;
    step();
    chk("t3_ack", ack_a, 1);
    chk("t3_cnt", cnt_a, 1);
    chk("t3_valid", valid_a, 0);

    // 4: three words from the sender model
    do_reset();
    dout_ready = 1'b1;
    send_word(8'h01, "t4_w1");
    send_word(8'h02, "t4_w2");
    send_word(8'h03, "t4_w3");
    chk("t4_ack", ack_a, 1);
    chk("t4_cnt", cnt_a, 3);
    chk("t4_err", err_a, 0);

    // Acceptance coinciding with a new synced flip: not an overrun, next word captured right after
    dout_ready = 1'b0;
    data_in = 8'h44; req_tgl = ~req_tgl;
    repeat (3) step();
    chk("bb_first_valid", valid_a, 1);
    data_in = 8'h55; req_tgl = ~req_tgl;
    step(); step();
    dout_ready = 1'b1;
    step();
    chk("bb_acc_err", err_a, 0);
    chk("bb_acc_ack", ack_a, 0);
    chk("bb_acc_cnt", cnt_a, 4);
    step();
    chk("bb_next_valid", valid_a, 1);
    chk("bb_next_dout", dout_a, 8'h55);
    step();
    chk("bb_next_ack", ack_a, 1);
    chk("bb_err_final", err_a, 0);

    // 5: overrun - one word held, then two extra flips 4 cycles apart cancel in parity
    do_reset();
    dout_ready = 1'b0;
    data_in = 8'h5A; req_tgl = 1'b1;
    repeat (3) step();
    chk("t5_valid", valid_a, 1);
    data_in = 8'h77; req_tgl = 1'b0;
    step(); step();
    chk("t5_err_not_yet", err_a, 0);
    step();
    chk("t5_err_set", err_a, 1);
    step();
    req_tgl = 1'b1;
    repeat (4) step();
    chk("t5_err_sticky", err_a, 1);
    chk("t5_dout_first", dout_a, 8'h5A);
    chk("t5_valid_held", valid_a, 1);
    dout_ready = 1'b1;
    step();
    chk("t5_acc_ack", ack_a, 1);
    chk("t5_acc_valid", valid_a, 0);
    repeat (4) step();
    chk("t5_no_second", valid_a, 0);
    chk("t5_cnt", cnt_a, 1);
    chk("t5_err_still", err_a, 1);
    chk("t5_dout_kept", dout_a, 8'h5A);

    // 6: counter wrap on the 2-bit instance, then reset while holding a word
    do_reset();
    dout_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_word(8'h10 + 8'(i), $sformatf("t6_w%0d", i));
      chk($sformatf("t6_cnt_b%0d", i), cnt_b, exp_b[i]);
      chk($sformatf("t6_cnt_a%0d", i), cnt_a, i + 1);
    end
    dout_ready = 1'b0;
    data_in = 8'hEE; req_tgl = ~req_tgl;
    repeat (3) step();
    chk("t6_hold_valid", valid_b, 1);
    req_tgl = ~req_tgl;
    repeat (3) step();
    chk("t6_hold_err", err_b, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rst_valid_b", valid_b, 0);
    chk("t6_rst_cnt_b", cnt_b, 0);
    chk("t6_rst_err_b", err_b, 0);
    chk("t6_rst_ack_b", ack_b, 0);
    chk("t6_rst_cnt_a", cnt_a, 0);
    // req_tgl is 1 here, so the receiver sees a fresh request once it is re-synced
    data_in = 8'hC3;
    step(); step();
    chk("t6_post_pre", valid_a, 0);
    step();
    chk("t6_post_valid", valid_a, 1);
    chk("t6_post_dout", dout_a, 8'hC3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
